// File: rtl/osmlgd_top.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// osmlgd_top
// One-step majority-logic decoder for a binary LDPC code (N = 256 bits,
// M = 128 parity checks). A received hard-decision word is captured on an
// accepted `work` pulse. All syndromes are computed in one cycle. Each bit then
// collects votes from the failed checks that contain it, RPC rows per cycle.
// A bit is flipped only when a strict majority of its checks have failed.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   work       start strobe, honoured only while free = 1
//   tx[N]      received word, captured on the accepted work edge
//   free       idle and ready to accept work
//   deout[N]   decoded word, held until the next completion
//   valid      one-cycle pulse marking a new deout
//   state_dbg  current FSM state (0 IDLE, 1 SYND, 2 VOTE, 3 DONE)
//
// Handshake: a word is accepted on any rising edge where work = 1 and free = 1.
// free stays low from that edge until the edge that raises valid, and the two
// rise together. work seen while free = 0 is dropped and has no effect.
//
// Optional feature (macro OSMLGD_ZERO_SYND_SKIP_EN): when every syndrome is
// zero, the vote phase is skipped and the word is returned unchanged two edges
// after acceptance.
//
// Harray holds the parity-check matrix. Bit j of row i is H(i,j). It has no
// reset and no write port, and is preloaded from outside the design.
// -----------------------------------------------------------------------------
module osmlgd_top #(
  parameter int N   = 256,
  parameter int M   = 128,
  parameter int RPC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         work,
  input  logic [N-1:0] tx,
  output logic         free,
  output logic [N-1:0] deout,
  output logic         valid,
  output logic [1:0]   state_dbg
);

  localparam int PW = $clog2(M);  // row pointer width
  localparam int CW = 8;          // vote counter width, holds 0..128 without wrap

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYND = 2'd1,
    VOTE = 2'd2,
    DONE = 2'd3
  } state_t;

  logic [N-1:0] Harray [0:M-1];

  state_t        state_q, state_d;
  logic [N-1:0]  y_q, y_d;
  logic [M-1:0]  s_q, s_d;
  logic [PW-1:0] p_q, p_d;
  logic [CW-1:0] f_q [N];
  logic [CW-1:0] f_d [N];
  logic [CW-1:0] w_q [N];
  logic [CW-1:0] w_d [N];
  logic [N-1:0]  deout_q, deout_d;
  logic          valid_q, valid_d;
  logic          free_q, free_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      s_q     <= '0;
      p_q     <= '0;
      deout_q <= '0;
      valid_q <= 1'b0;
      free_q  <= 1'b1;
      for (int j = 0; j < N; j++) begin
        f_q[j] <= '0;
        w_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      s_q     <= s_d;
      p_q     <= p_d;
      deout_q <= deout_d;
      valid_q <= valid_d;
      free_q  <= free_d;
      for (int j = 0; j < N; j++) begin
        f_q[j] <= f_d[j];
        w_q[j] <= w_d[j];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    s_d     = s_q;
    p_d     = p_q;
    deout_d = deout_q;
    valid_d = 1'b0;  // valid is a single-cycle pulse
    free_d  = free_q;
    for (int j = 0; j < N; j++) begin
      f_d[j] = f_q[j];
      w_d[j] = w_q[j];
    end

    unique case (state_q)
      IDLE: begin
        if (work) begin
          y_d    = tx;
          free_d = 1'b0;
          for (int j = 0; j < N; j++) begin
            f_d[j] = '0;
            w_d[j] = '0;
          end
          state_d = SYND;
        end
      end

      SYND: begin
        for (int i = 0; i < M; i++) begin
          s_d[i] = ^(Harray[i] & y_q);
        end
        p_d = '0;
`ifdef OSMLGD_ZERO_SYND_SKIP_EN
        // With every check satisfied no bit can collect a vote, so voting is skipped.
        state_d = (s_d == '0) ? DONE : VOTE;
`else
        state_d = VOTE;
`endif
      end

      VOTE: begin
        // w counts the checks that touch a bit. f counts how many of them failed.
        for (int r = 0; r < RPC; r++) begin
          for (int j = 0; j < N; j++) begin
            w_d[j] = w_d[j] + CW'(Harray[p_q + PW'(r)][j]);
            f_d[j] = f_d[j] + CW'(Harray[p_q + PW'(r)][j] & s_q[p_q + PW'(r)]);
          end
        end
        if (p_q == PW'(M - RPC)) begin
          state_d = DONE;
        end else begin
          p_d = p_q + PW'(RPC);
        end
      end

      DONE: begin
        // 2f > w is a strict majority. A tie or a zero-weight column leaves the bit alone.
        for (int j = 0; j < N; j++) begin
          deout_d[j] = y_q[j] ^ ({f_q[j], 1'b0} > {1'b0, w_q[j]});
        end
        valid_d = 1'b1;
        free_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign free      = free_q;
  assign deout     = deout_q;
  assign valid     = valid_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_osmlgd_top.sv
`timescale 1ns/1ps
// Bench for osmlgd_top.
// The bench uses an H matrix with the following structure:
// - Row i has ones in columns i, i+1 and i+5 (mod 128).
// - The difference set {0,1,5} gives the low 128 columns weight 3.
// - Any two of those columns share at most one row.
// - Column 250 is added to rows 50 and 60 and has weight 2. It is the tie column.
// - Every other column in 128..255 has weight 0 and passes through unchanged.
module tb_osmlgd_top;
  localparam int N   = 256;
  localparam int M   = 128;
  localparam int RPC = 4;
  localparam int NV  = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         work = 1'b0;
  logic [N-1:0] tx = '0;
  logic         free;
  logic [N-1:0] deout;
  logic         valid;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_count = 0;

  logic [N-1:0] h_tb [M];
  logic [N-1:0] exp_q [$];
  int           lat_q [$];

  typedef struct {
    logic [N-1:0] tx;
    logic [N-1:0] exp;
  } vec_t;
  vec_t  vecs [NV];
  string vec_name [NV];

  osmlgd_top #(.N(N), .M(M), .RPC(RPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .work      (work),
    .tx        (tx),
    .free      (free),
    .deout     (deout),
    .valid     (valid),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  always @(negedge clk) if (valid) valid_count++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [M-1:0] syn(input logic [N-1:0] y);
    logic [M-1:0] s;
    for (int i = 0; i < M; i++) s[i] = ^(h_tb[i] & y);
    return s;
  endfunction

  function automatic logic [N-1:0] model_decode(input logic [N-1:0] y);
    logic [N-1:0] r;
    logic [M-1:0] s;
    int f, w;
    r = y;
    s = syn(y);
    for (int j = 0; j < N; j++) begin
      f = 0;
      w = 0;
      for (int i = 0; i < M; i++) begin
        if (h_tb[i][j]) begin
          w++;
          if (s[i]) f++;
        end
      end
      if (2 * f > w) r[j] = ~r[j];
    end
    return r;
  endfunction

  function automatic int exp_lat(input logic [N-1:0] y);
`ifdef OSMLGD_ZERO_SYND_SKIP_EN
    if (syn(y) == '0) return 2;
`endif
    return 2 + M / RPC;
  endfunction

  function automatic logic [N-1:0] bitv(input int idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] rand_word();
    logic [N-1:0] v;
    for (int b = 0; b < N / 32; b++) v[b*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entry and exit are both #1 after a rising edge.
  task automatic run_word(input logic [N-1:0] word, input logic [N-1:0] exp,
                          input string name, input bit poke);
    int n;
    int lat;
    int vc0;
    lat = exp_lat(word);
    n = 0;
    while (!free && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " free_before"}, N'(free), N'(1));
    vc0  = valid_count;
    work = 1'b1;
    tx   = word;
    @(posedge clk); #1;
    work = 1'b0;
    tx   = ~word;
    n = 0;
    while (!valid && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (poke && n == 9) begin
        work = 1'b1;
        tx   = '1;
      end
      if (poke && n == 10) work = 1'b0;
    end
    check({name, " latency"}, N'(n), N'(lat));
    check({name, " deout"}, deout, exp);
    check({name, " free_at_valid"}, N'(free), N'(1));
    @(posedge clk); #1;
    check({name, " valid_width"}, N'(valid), N'(0));
    check({name, " valid_pulses"}, N'(valid_count - vc0), N'(1));
  endtask

  task automatic gen_b2b(input int k, output logic [N-1:0] w);
    if (k % 2 == 0) begin
      // A codeword built from the free high columns, plus 0..2 errors in the low half.
      w = {rand_word() >> 128};
      w = w << 128;
      w[250] = 1'b0;
      for (int e = 0; e < k % 3; e++) w[$urandom_range(0, M - 1)] ^= 1'b1;
    end else begin
      w = rand_word();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [N-1:0] h, c, u, word, e;
    int n, l, vc0;

    for (int i = 0; i < M; i++) begin
      h = '0;
      h[i] = 1'b1;
      h[(i + 1) % M] = 1'b1;
      h[(i + 5) % M] = 1'b1;
      if (i == 50 || i == 60) h[250] = 1'b1;
      h_tb[i] = h;
      dut.Harray[i] = h;
    end

    // Vector table (expected values worked out by hand from the H structure).
    c = {128'h0123456789ABCDEF0123456789ABCDEF, 128'h0};
    u = {{128{1'b1}}, 128'h0};
    u[250] = 1'b0;
    vecs[0] = '{tx: '0,                                   exp: '0};
    vec_name[0] = "zero_codeword";
    vecs[1] = '{tx: bitv(17),                             exp: '0};
    vec_name[1] = "err_bit17";
    vecs[2] = '{tx: c ^ bitv(17),                         exp: c};
    vec_name[2] = "codeword_c_err17";
    vecs[3] = '{tx: bitv(250) | bitv(50) | bitv(201),     exp: bitv(250) | bitv(201)};
    vec_name[3] = "tie_and_zero_weight";
    vecs[4] = '{tx: bitv(17) | bitv(100),                 exp: '0};
    vec_name[4] = "two_far_errors";
    vecs[5] = '{tx: u,                                    exp: u};
    vec_name[5] = "upper_codeword";

    // Reset behaviour
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset free", N'(free), N'(1));
    check("reset valid", N'(valid), N'(0));
    check("reset deout", deout, '0);
    check("reset state", N'(state_dbg), N'(0));
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle no_valid", N'(valid_count), N'(0));
    check("idle free", N'(free), N'(1));

    // Table-driven vectors
    for (int v = 0; v < NV; v++) run_word(vecs[v].tx, vecs[v].exp, vec_name[v], 1'b0);

    // Busy: a second work pulse with a different tx mid-VOTE is ignored.
    run_word(c ^ bitv(17), c, "busy_ignored", 1'b1);

    // Abort: reset mid-VOTE.
    work = 1'b1;
    tx   = c ^ bitv(17);
    @(posedge clk); #1;
    work = 1'b0;
    vc0  = valid_count;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort free", N'(free), N'(1));
    check("abort valid", N'(valid), N'(0));
    check("abort deout", deout, '0);
    check("abort state", N'(state_dbg), N'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("abort no_valid", N'(valid_count - vc0), N'(0));
    run_word(bitv(17), '0, "after_abort", 1'b0);

    // Back-to-back random words against the model, with work raised in each valid cycle.
    vc0 = valid_count;
    gen_b2b(0, word);
    work = 1'b1;
    tx   = word;
    exp_q.push_back(model_decode(word));
    lat_q.push_back(exp_lat(word));
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      work = 1'b0;
      tx   = rand_word();
      n = 0;
      while (!valid && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      e = exp_q.pop_front();
      l = lat_q.pop_front();
      check($sformatf("b2b[%0d] spacing", k), N'(n + 1), N'(l + 1));
      check($sformatf("b2b[%0d] deout", k), deout, e);
      if (k < 99) begin
        gen_b2b(k + 1, word);
        work = 1'b1;
        tx   = word;
        exp_q.push_back(model_decode(word));
        lat_q.push_back(exp_lat(word));
      end
    end
    @(posedge clk); #1;
    check("b2b pulse_count", N'(valid_count - vc0), N'(100));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
